// File: rtl/rob.sv
// Reorder buffer: allocates in-order tags at dispatch, collects out-of-order
// CDB results, serves in-flight operands, and retires in program order.
module rob #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Disp_en_rob,
  input  logic [4:0]        Disp_rd_rob,
  input  logic              Disp_wr_rob,
  output logic [TAG_W-1:0]  Disp_tag_rob,
  output logic              Full_rob,
  output logic              Empty_rob,
  output logic [TAG_W:0]    Count_rob,
  input  logic              Cdb_valid_rob,
  input  logic [TAG_W-1:0]  Cdb_tag_rob,
  input  logic [DATA_W-1:0] Cdb_data_rob,
  input  logic [TAG_W-1:0]  Rstag_rob,
  output logic [DATA_W-1:0] Rsdata_rob,
  output logic              Rsready_rob,
  input  logic [TAG_W-1:0]  Rttag_rob,
  output logic [DATA_W-1:0] Rtdata_rob,
  output logic              Rtready_rob,
  input  logic              Flush_rob,
  output logic              RB_valid_rst,
  output logic [TAG_W-1:0]  RB_tag_rst,
  output logic [4:0]        Commit_addr_rob,
  output logic [DATA_W-1:0] Commit_data_rob,
  output logic              Commit_wen_rob
);
  localparam int DEPTH = 1 << TAG_W;

  // Per-entry control state (reset) and payload (not reset; gated by valid).
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, wr_q, wr_d;
  logic [4:0]        rd_q   [DEPTH];
  logic [4:0]        rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              rb_valid_q, rb_valid_d, commit_wen_q, commit_wen_d;
  logic [TAG_W-1:0]  rb_tag_q, rb_tag_d;
  logic [4:0]        commit_addr_q, commit_addr_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;

  logic disp_acc, commit, cdb_hit;

  assign Full_rob        = (count_q == (TAG_W+1)'(DEPTH));
  assign Empty_rob       = (count_q == '0);
  assign Count_rob       = count_q;
  assign Disp_tag_rob    = tail_q;
  assign RB_valid_rst    = rb_valid_q;
  assign RB_tag_rst      = rb_tag_q;
  assign Commit_addr_rob = commit_addr_q;
  assign Commit_data_rob = commit_data_q;
  assign Commit_wen_rob  = commit_wen_q;

  assign disp_acc = Disp_en_rob & ~Full_rob;
  assign commit   = valid_q[head_q] & done_q[head_q];
  assign cdb_hit  = Cdb_valid_rob & valid_q[Cdb_tag_rob];

  // Next state: flush wins; otherwise completion, commit and dispatch touch
  // disjoint entries (head==tail only when empty or full).
  always_comb begin
    valid_d       = valid_q;
    done_d        = done_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    data_d        = data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    rb_valid_d    = 1'b0;
    commit_wen_d  = 1'b0;
    rb_tag_d      = rb_tag_q;
    commit_addr_d = commit_addr_q;
    commit_data_d = commit_data_q;
    if (Flush_rob) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_hit) begin
        done_d[Cdb_tag_rob] = 1'b1;
        data_d[Cdb_tag_rob] = Cdb_data_rob;
      end
      if (commit) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + TAG_W'(1);
        rb_valid_d      = 1'b1;
        rb_tag_d        = head_q;
        commit_addr_d   = rd_q[head_q];
        commit_data_d   = data_q[head_q];
        commit_wen_d    = wr_q[head_q];
      end
      if (disp_acc) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        wr_d[tail_q]    = Disp_wr_rob;
        rd_d[tail_q]    = Disp_rd_rob;
        tail_d          = tail_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(disp_acc) - (TAG_W+1)'(commit);
    end
  end

  // Operand lookup: CDB bypass first, then stored value of a valid entry.
  always_comb begin
    Rsdata_rob  = '0;
    Rsready_rob = 1'b0;
    Rtdata_rob  = '0;
    Rtready_rob = 1'b0;
    if (Cdb_valid_rob && (Cdb_tag_rob == Rstag_rob)) begin
      Rsdata_rob  = Cdb_data_rob;
      Rsready_rob = 1'b1;
    end else if (valid_q[Rstag_rob]) begin
      Rsdata_rob  = data_q[Rstag_rob];
      Rsready_rob = done_q[Rstag_rob];
    end
    if (Cdb_valid_rob && (Cdb_tag_rob == Rttag_rob)) begin
      Rtdata_rob  = Cdb_data_rob;
      Rtready_rob = 1'b1;
    end else if (valid_q[Rttag_rob]) begin
      Rtdata_rob  = data_q[Rttag_rob];
      Rtready_rob = done_q[Rttag_rob];
    end
  end

  // Control state and registered commit outputs, asynchronously reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      done_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rb_valid_q    <= 1'b0;
      rb_tag_q      <= '0;
      commit_addr_q <= '0;
      commit_data_q <= '0;
      commit_wen_q  <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      done_q        <= done_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rb_valid_q    <= rb_valid_d;
      rb_tag_q      <= rb_tag_d;
      commit_addr_q <= commit_addr_d;
      commit_data_q <= commit_data_d;
      commit_wen_q  <= commit_wen_d;
    end
  end

  // Entry payload; meaningful only while the entry's valid bit is set.
  always_ff @(posedge clock) begin
    wr_q   <= wr_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: commit scoreboard plus per-scenario checks.
module tb_rob;
  logic        clock, reset;
  logic        Disp_en_rob, Disp_wr_rob;
  logic [4:0]  Disp_rd_rob, Disp_tag_rob;
  logic        Full_rob, Empty_rob;
  logic [5:0]  Count_rob;
  logic        Cdb_valid_rob;
  logic [4:0]  Cdb_tag_rob;
  logic [31:0] Cdb_data_rob;
  logic [4:0]  Rstag_rob, Rttag_rob;
  logic [31:0] Rsdata_rob, Rtdata_rob;
  logic        Rsready_rob, Rtready_rob;
  logic        Flush_rob;
  logic        RB_valid_rst;
  logic [4:0]  RB_tag_rst, Commit_addr_rob;
  logic [31:0] Commit_data_rob;
  logic        Commit_wen_rob;

  rob #(.TAG_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .Disp_en_rob(Disp_en_rob), .Disp_rd_rob(Disp_rd_rob), .Disp_wr_rob(Disp_wr_rob),
    .Disp_tag_rob(Disp_tag_rob), .Full_rob(Full_rob), .Empty_rob(Empty_rob),
    .Count_rob(Count_rob), .Cdb_valid_rob(Cdb_valid_rob), .Cdb_tag_rob(Cdb_tag_rob),
    .Cdb_data_rob(Cdb_data_rob), .Rstag_rob(Rstag_rob), .Rsdata_rob(Rsdata_rob),
    .Rsready_rob(Rsready_rob), .Rttag_rob(Rttag_rob), .Rtdata_rob(Rtdata_rob),
    .Rtready_rob(Rtready_rob), .Flush_rob(Flush_rob), .RB_valid_rst(RB_valid_rst),
    .RB_tag_rst(RB_tag_rst), .Commit_addr_rob(Commit_addr_rob),
    .Commit_data_rob(Commit_data_rob), .Commit_wen_rob(Commit_wen_rob)
  );

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        wen;
    int          cyc;
  } cm_t;

  cm_t exp_q[$];
  cm_t obs_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  logic [4:0] tb_tail = 5'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  // Advance one cycle; log any commit the DUT produces.
  task automatic step();
    cm_t o;
    @(posedge clock);
    #1;
    cyc++;
    if (RB_valid_rst === 1'b1) begin
      o.tag = RB_tag_rst; o.addr = Commit_addr_rob; o.data = Commit_data_rob;
      o.wen = Commit_wen_rob; o.cyc = cyc;
      obs_q.push_back(o);
    end
  endtask

  task automatic push_exp(input logic [4:0] tag, input logic [4:0] addr,
                          input logic [31:0] data, input logic wen);
    cm_t e;
    e.tag = tag; e.addr = addr; e.data = data; e.wen = wen; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    Disp_en_rob = 1'b1; Disp_rd_rob = 5'd7; Disp_wr_rob = 1'b1;
    n_checks++; if (Disp_tag_rob !== 5'd0) $display("FAIL rst_first_tag got %0d want 0", Disp_tag_rob); else n_pass++;
    step();
    Disp_rd_rob = 5'd8;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd0; Cdb_data_rob = 32'h11;
    step();
    Disp_en_rob = 1'b0; Cdb_valid_rob = 1'b0;
    step();
    n_checks++; if (RB_valid_rst !== 1'b1) $display("FAIL rst_pre_commit got %b want 1", RB_valid_rst); else n_pass++;
    n_checks++; if (Count_rob !== 6'd1) $display("FAIL rst_pre_count got %0d want 1", Count_rob); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (RB_valid_rst !== 1'b0) $display("FAIL rst_async_rbvalid got %b want 0", RB_valid_rst); else n_pass++;
    n_checks++; if (Empty_rob !== 1'b1) $display("FAIL rst_async_empty got %b want 1", Empty_rob); else n_pass++;
    n_checks++; if (Count_rob !== 6'd0) $display("FAIL rst_async_count got %0d want 0", Count_rob); else n_pass++;
    n_checks++; if (Disp_tag_rob !== 5'd0) $display("FAIL rst_async_tag got %0d want 0", Disp_tag_rob); else n_pass++;
    n_checks++; if (Commit_data_rob !== 32'h0) $display("FAIL rst_async_cdata got %h want 0", Commit_data_rob); else n_pass++;
    obs_q.delete();
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    n_checks++; if (obs_q.size() != 0) $display("FAIL rst_no_stale_commit got %0d want 0", obs_q.size()); else n_pass++;
    n_checks++; if (Full_rob !== 1'b0) $display("FAIL rst_full got %b want 0", Full_rob); else n_pass++;
    obs_q.delete();
    tb_tail = 5'd0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      Disp_en_rob = 1'b1; Disp_rd_rob = 5'(i); Disp_wr_rob = 1'b1;
      n_checks++; if (Disp_tag_rob !== 5'(i)) $display("FAIL fill_tag got %0d want %0d", Disp_tag_rob, i); else n_pass++;
      step();
    end
    Disp_en_rob = 1'b0;
    n_checks++; if (Full_rob !== 1'b1) $display("FAIL fill_full got %b want 1", Full_rob); else n_pass++;
    n_checks++; if (Count_rob !== 6'd32) $display("FAIL fill_count got %0d want 32", Count_rob); else n_pass++;
    n_checks++; if (Empty_rob !== 1'b0) $display("FAIL fill_empty got %b want 0", Empty_rob); else n_pass++;
    Disp_en_rob = 1'b1;
    step();
    Disp_en_rob = 1'b0;
    n_checks++; if (Count_rob !== 6'd32) $display("FAIL fill_drop_count got %0d want 32", Count_rob); else n_pass++;
    n_checks++; if (Disp_tag_rob !== 5'd0) $display("FAIL fill_drop_tail got %0d want 0", Disp_tag_rob); else n_pass++;
    Flush_rob = 1'b1;
    step();
    Flush_rob = 1'b0;
    n_checks++; if (Empty_rob !== 1'b1) $display("FAIL fill_flush_empty got %b want 1", Empty_rob); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL fill_no_commit got %0d want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
    tb_tail = 5'd0;
  endtask

  task automatic test_out_of_order();
    cm_t o, e;
    for (int i = 0; i < 3; i++) begin
      Disp_en_rob = 1'b1; Disp_rd_rob = 5'(3 + i); Disp_wr_rob = 1'b1;
      push_exp(tb_tail, 5'(3 + i), 32'hA + 32'(i), 1'b1);
      tb_tail++;
      step();
    end
    Disp_en_rob = 1'b0;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd2; Cdb_data_rob = 32'hC; step();
    Cdb_tag_rob = 5'd1; Cdb_data_rob = 32'hB; step();
    n_checks++; if (obs_q.size() != 0) $display("FAIL ooo_early_commit got %0d want 0", obs_q.size()); else n_pass++;
    Cdb_tag_rob = 5'd0; Cdb_data_rob = 32'hA; step();
    Cdb_valid_rob = 1'b0;
    n_checks++; if (obs_q.size() != 0) $display("FAIL ooo_same_edge_commit got %0d want 0", obs_q.size()); else n_pass++;
    step(); step(); step(); step();
    n_checks++; if (obs_q.size() != 3) $display("FAIL ooo_commit_count got %0d want 3", obs_q.size()); else n_pass++;
    if (obs_q.size() == 3) begin
      n_checks++; if (obs_q[1].cyc != obs_q[0].cyc + 1 || obs_q[2].cyc != obs_q[1].cyc + 1)
        $display("FAIL ooo_consecutive got cycles %0d,%0d,%0d want consecutive", obs_q[0].cyc, obs_q[1].cyc, obs_q[2].cyc);
      else n_pass++;
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.tag, o.addr, o.data, o.wen} !== {e.tag, e.addr, e.data, e.wen})
        $display("FAIL ooo_commit got tag=%0d addr=%0d data=%h wen=%b want tag=%0d addr=%0d data=%h wen=%b",
                 o.tag, o.addr, o.data, o.wen, e.tag, e.addr, e.data, e.wen);
      else n_pass++;
    end
    n_checks++; if (Empty_rob !== 1'b1) $display("FAIL ooo_empty got %b want 1", Empty_rob); else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bypass();
    cm_t o, e;
    Flush_rob = 1'b1; step(); Flush_rob = 1'b0;
    obs_q.delete(); tb_tail = 5'd0;
    Disp_en_rob = 1'b1; Disp_wr_rob = 1'b1; Disp_rd_rob = 5'd9;
    push_exp(5'd0, 5'd9, 32'h66, 1'b1); step();
    Disp_rd_rob = 5'd10;
    push_exp(5'd1, 5'd10, 32'h55, 1'b1); step();
    Disp_en_rob = 1'b0; tb_tail = 5'd2;
    Rstag_rob = 5'd1; Rttag_rob = 5'd0;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd1; Cdb_data_rob = 32'h55;
    #1;
    n_checks++; if (Rsdata_rob !== 32'h55) $display("FAIL byp_cdb_data got %h want 55", Rsdata_rob); else n_pass++;
    n_checks++; if (Rsready_rob !== 1'b1) $display("FAIL byp_cdb_ready got %b want 1", Rsready_rob); else n_pass++;
    n_checks++; if (Rtready_rob !== 1'b0) $display("FAIL byp_pending_ready got %b want 0", Rtready_rob); else n_pass++;
    step();
    Cdb_valid_rob = 1'b0;
    #1;
    n_checks++; if (Rsdata_rob !== 32'h55) $display("FAIL byp_store_data got %h want 55", Rsdata_rob); else n_pass++;
    n_checks++; if (Rsready_rob !== 1'b1) $display("FAIL byp_store_ready got %b want 1", Rsready_rob); else n_pass++;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd5; Cdb_data_rob = 32'h77; step();
    Cdb_valid_rob = 1'b0; Rttag_rob = 5'd5;
    #1;
    n_checks++; if (Rtready_rob !== 1'b0) $display("FAIL byp_invalid_ready got %b want 0", Rtready_rob); else n_pass++;
    n_checks++; if (Rtdata_rob !== 32'h0) $display("FAIL byp_invalid_data got %h want 0", Rtdata_rob); else n_pass++;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd0; Cdb_data_rob = 32'h66; step();
    Cdb_valid_rob = 1'b0;
    step(); step(); step();
    n_checks++; if (obs_q.size() != 2) $display("FAIL byp_commit_count got %0d want 2", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.tag, o.addr, o.data, o.wen} !== {e.tag, e.addr, e.data, e.wen})
        $display("FAIL byp_commit got tag=%0d addr=%0d data=%h wen=%b want tag=%0d addr=%0d data=%h wen=%b",
                 o.tag, o.addr, o.data, o.wen, e.tag, e.addr, e.data, e.wen);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    cm_t o, e;
    while (tb_tail != 5'd31) begin
      Disp_en_rob = 1'b1; Disp_wr_rob = 1'b1; Disp_rd_rob = tb_tail;
      push_exp(tb_tail, tb_tail, 32'h100 + 32'(tb_tail), 1'b1);
      step();
      Disp_en_rob = 1'b0;
      Cdb_valid_rob = 1'b1; Cdb_tag_rob = tb_tail; Cdb_data_rob = 32'h100 + 32'(tb_tail);
      step();
      Cdb_valid_rob = 1'b0;
      tb_tail++;
    end
    step(); step();
    n_checks++; if (Count_rob !== 6'd0) $display("FAIL wrap_pre_count got %0d want 0", Count_rob); else n_pass++;
    n_checks++; if (Disp_tag_rob !== 5'd31) $display("FAIL wrap_pre_tag got %0d want 31", Disp_tag_rob); else n_pass++;
    Disp_en_rob = 1'b1; Disp_wr_rob = 1'b0; Disp_rd_rob = 5'd1;
    push_exp(5'd31, 5'd1, 32'h31, 1'b0);
    step();
    Disp_wr_rob = 1'b1; Disp_rd_rob = 5'd2;
    push_exp(5'd0, 5'd2, 32'h200, 1'b1);
    n_checks++; if (Disp_tag_rob !== 5'd0) $display("FAIL wrap_tag0 got %0d want 0", Disp_tag_rob); else n_pass++;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd31; Cdb_data_rob = 32'h31;
    step();
    Cdb_valid_rob = 1'b0; Disp_rd_rob = 5'd3;
    push_exp(5'd1, 5'd3, 32'h201, 1'b1);
    n_checks++; if (Disp_tag_rob !== 5'd1) $display("FAIL wrap_tag1 got %0d want 1", Disp_tag_rob); else n_pass++;
    n_checks++; if (Count_rob !== 6'd2) $display("FAIL wrap_count_before got %0d want 2", Count_rob); else n_pass++;
    step();
    Disp_en_rob = 1'b0;
    n_checks++; if (Count_rob !== 6'd2) $display("FAIL wrap_count_same got %0d want 2", Count_rob); else n_pass++;
    n_checks++; if (RB_valid_rst !== 1'b1 || Commit_wen_rob !== 1'b0)
      $display("FAIL wrap_nowr_commit got valid=%b wen=%b want valid=1 wen=0", RB_valid_rst, Commit_wen_rob);
    else n_pass++;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd0; Cdb_data_rob = 32'h200; step();
    Cdb_tag_rob = 5'd1; Cdb_data_rob = 32'h201; step();
    Cdb_valid_rob = 1'b0;
    step(); step();
    tb_tail = 5'd2;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL wrap_commit_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.tag, o.addr, o.data, o.wen} !== {e.tag, e.addr, e.data, e.wen})
        $display("FAIL wrap_commit got tag=%0d addr=%0d data=%h wen=%b want tag=%0d addr=%0d data=%h wen=%b",
                 o.tag, o.addr, o.data, o.wen, e.tag, e.addr, e.data, e.wen);
      else n_pass++;
    end
    n_checks++; if (Empty_rob !== 1'b1) $display("FAIL wrap_empty got %b want 1", Empty_rob); else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    cm_t o, e;
    for (int i = 0; i < 5; i++) begin
      Disp_en_rob = 1'b1; Disp_wr_rob = 1'b1; Disp_rd_rob = 5'(20 + i);
      step();
    end
    Disp_en_rob = 1'b0;
    n_checks++; if (Count_rob !== 6'd5) $display("FAIL flush_pre_count got %0d want 5", Count_rob); else n_pass++;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd2; Cdb_data_rob = 32'h22; step();
    Flush_rob = 1'b1; Disp_en_rob = 1'b1; Cdb_tag_rob = 5'd3; Cdb_data_rob = 32'h99;
    step();
    Flush_rob = 1'b0; Disp_en_rob = 1'b0; Cdb_valid_rob = 1'b0;
    Rstag_rob = 5'd3; Rttag_rob = 5'd2;
    #1;
    n_checks++; if (Count_rob !== 6'd0) $display("FAIL flush_count got %0d want 0", Count_rob); else n_pass++;
    n_checks++; if (Disp_tag_rob !== 5'd0) $display("FAIL flush_tail got %0d want 0", Disp_tag_rob); else n_pass++;
    n_checks++; if (RB_valid_rst !== 1'b0) $display("FAIL flush_no_pulse got %b want 0", RB_valid_rst); else n_pass++;
    n_checks++; if (Rsready_rob !== 1'b0 || Rsdata_rob !== 32'h0)
      $display("FAIL flush_discard got ready=%b data=%h want ready=0 data=0", Rsready_rob, Rsdata_rob);
    else n_pass++;
    n_checks++; if (Rtready_rob !== 1'b0) $display("FAIL flush_done_cleared got %b want 0", Rtready_rob); else n_pass++;
    step(); step();
    n_checks++; if (obs_q.size() != 0) $display("FAIL flush_no_commit got %0d want 0", obs_q.size()); else n_pass++;
    Disp_en_rob = 1'b1; Disp_rd_rob = 5'd12; Disp_wr_rob = 1'b1;
    push_exp(5'd0, 5'd12, 32'h5A, 1'b1);
    step();
    Disp_en_rob = 1'b0;
    Cdb_valid_rob = 1'b1; Cdb_tag_rob = 5'd0; Cdb_data_rob = 32'h5A; step();
    Cdb_valid_rob = 1'b0;
    step(); step();
    n_checks++; if (obs_q.size() != 1) $display("FAIL flush_after_count got %0d want 1", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.tag, o.addr, o.data, o.wen} !== {e.tag, e.addr, e.data, e.wen})
        $display("FAIL flush_after_commit got tag=%0d addr=%0d data=%h wen=%b want tag=%0d addr=%0d data=%h wen=%b",
                 o.tag, o.addr, o.data, o.wen, e.tag, e.addr, e.data, e.wen);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    Disp_en_rob = 1'b0; Disp_rd_rob = 5'd0; Disp_wr_rob = 1'b0;
    Cdb_valid_rob = 1'b0; Cdb_tag_rob = 5'd0; Cdb_data_rob = 32'h0;
    Rstag_rob = 5'd0; Rttag_rob = 5'd0; Flush_rob = 1'b0;
    step(); step();
    reset = 1'b0;
    obs_q.delete();
    n_checks++; if (Empty_rob !== 1'b1) $display("FAIL init_empty got %b want 1", Empty_rob); else n_pass++;
    n_checks++; if (Commit_wen_rob !== 1'b0) $display("FAIL init_wen got %b want 0", Commit_wen_rob); else n_pass++;
    test_reset();
    test_fill();
    test_out_of_order();
    test_bypass();
    test_wrap();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
